// File: rtl/track_sensor_conditioner.sv
// Purpose: synchronize/debounce two wheel detectors, count axles, emit sensor_A/sensor_B pulses and fault flags.
// Latency: raw rise stable from edge k -> pulse/count update registered at edge k+DEBOUNCE_CYCLES+3.
// Backpressure: none; inputs are sampled every cycle and outputs cannot be stalled.
module track_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AXLE_W          = 8,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              raw_A,
  input  logic              raw_B,
  input  logic              clear_fault,
  output logic              sensor_A,
  output logic              sensor_B,
  output logic              occupied,
  output logic              fault,
  output logic [AXLE_W-1:0] axle_count
);

  localparam int                 TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]         DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AXLE_W-1:0]  CNT_MAX  = '1;
  localparam logic [AXLE_W-1:0]  CNT_ONE  = AXLE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OCC   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // Channel 0 is the approach side (A), channel 1 the exit side (B).
  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      deb;
  logic [1:0]      deb_d;
  logic [1:0]      rise;
  logic [1:0][7:0] db_cnt;
  logic            rise_a;
  logic            rise_b;

  state_t          state;
  logic [TMR_W-1:0] timer;

  assign raw    = {raw_B, raw_A};
  assign rise_a = rise[0];
  assign rise_b = rise[1];

  // Two-flop synchronizer for the asynchronous detector inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the level only follows the synchronized input after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb    <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Registered rising-edge strobes of the debounced levels; falling edges carry no meaning here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d <= '0;
      rise  <= '0;
    end else begin
      deb_d <= deb;
      rise  <= deb & ~deb_d;
    end
  end

  // Occupancy FSM with registered pulses, flags, axle count and stuck-track timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      axle_count <= '0;
      sensor_A   <= 1'b0;
      sensor_B   <= 1'b0;
      occupied   <= 1'b0;
      fault      <= 1'b0;
    end else begin
      sensor_A <= 1'b0;
      sensor_B <= 1'b0;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (rise_b) begin
            // Exit side first, or both at once: direction cannot be trusted.
            state    <= S_FAULT;
            occupied <= 1'b1;
            fault    <= 1'b1;
          end else if (rise_a) begin
            state      <= S_OCC;
            axle_count <= CNT_ONE;
            sensor_A   <= 1'b1;
            occupied   <= 1'b1;
          end
        end
        S_OCC: begin
          if (rise_a && rise_b) begin
            timer <= '0;
          end else if (rise_a) begin
            timer <= '0;
            if (axle_count == CNT_MAX) begin
              // Counter would wrap: hold the count and trap.
              state <= S_FAULT;
              fault <= 1'b1;
            end else begin
              axle_count <= axle_count + CNT_ONE;
            end
          end else if (rise_b) begin
            timer      <= '0;
            axle_count <= axle_count - CNT_ONE;
            if (axle_count == CNT_ONE) begin
              state    <= S_IDLE;
              sensor_B <= 1'b1;
              occupied <= 1'b0;
            end
          end else if (timer == TMR_LAST) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_FAULT: begin
          // Only leave once the track is physically quiet on both sides.
          if (clear_fault && (deb == 2'b00)) begin
            state      <= S_IDLE;
            axle_count <= '0;
            timer      <= '0;
            occupied   <= 1'b0;
            fault      <= 1'b0;
          end
        end
        default: begin
          state    <= S_FAULT;
          occupied <= 1'b1;
          fault    <= 1'b1;
        end
      endcase
    end
  end

endmodule
